// File: rtl/led_button_ctrl.sv
// led_button_ctrl: synchronised, debounced buttons cycling per-LED
// off/on/blink/inverse-blink modes; each LED is its mode state OR its switch.
// Ports: clk, rst (sync, active-high); btn raw buttons; sw raw switches;
//   led pins (board polarity, registered); btn_level debounced state;
//   btn_press / btn_long / blink_tick one-cycle pulses.
// Option: define LED_CTRL_LONGPRESS_EN for long-press detection (mode -> OFF).
module led_button_ctrl #(
  parameter int N_LED           = 6,
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int BLINK_HALF      = 27000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter bit LED_ACTIVE_LOW  = 1'b1,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_LED-1:0] sw,
  output logic [N_LED-1:0] led,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_long,
  output logic             blink_tick
);

  typedef enum logic [1:0] {
    M_OFF, M_ON, M_BLINK, M_INV
  } mode_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BL_MAX = BW'(BLINK_HALF - 1);

  logic [N_BTN-1:0] btn_m, btn_q, s;
  logic [N_LED-1:0] sw_m, sw_q;
  logic [DW-1:0]    db_cnt [N_BTN];
  logic [N_BTN-1:0] press_nxt, long_nxt;
  logic [BW-1:0]    bcnt;
  logic             blink, b_wrap;
  mode_t            mode [N_LED];
  logic [N_LED-1:0] adv, clr, lit;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= '0;
      btn_q <= '0;
      sw_m  <= '0;
      sw_q  <= '0;
    end else begin
      btn_m <= btn;
      btn_q <= btn_m;
      sw_m  <= sw;
      sw_q  <= sw_m;
    end
  end

  assign s = BTN_ACTIVE_LOW ? ~btn_q : btn_q;

  // A press fires on the sample that completes a stable run toward 1.
  always_comb begin
    press_nxt = '0;
    for (int i = 0; i < N_BTN; i++)
      press_nxt[i] = s[i] & ~btn_level[i] & (db_cnt[i] == DB_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      btn_press <= '0;
      for (int i = 0; i < N_BTN; i++)
        db_cnt[i] <= '0;
    end else begin
      btn_press <= press_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        if (s[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          btn_level[i] <= s[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef LED_CTRL_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LG_PRE = LW'(LONG_CYCLES - 2);
  localparam logic [LW-1:0] LG_MAX = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] hold [N_BTN];

  // Hold counter saturates at LONG_CYCLES-1, so one pulse per hold.
  always_comb begin
    long_nxt = '0;
    for (int i = 0; i < N_BTN; i++)
      long_nxt[i] = btn_level[i] & (hold[i] == LG_PRE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_long <= '0;
      for (int i = 0; i < N_BTN; i++)
        hold[i] <= '0;
    end else begin
      btn_long <= long_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn_level[i])
          hold[i] <= '0;
        else if (hold[i] != LG_MAX)
          hold[i] <= hold[i] + 1'b1;
      end
    end
  end
`else
  localparam int unused_long_cycles = LONG_CYCLES;
  assign long_nxt = '0;
  assign btn_long = '0;
`endif

  assign b_wrap = (bcnt == BL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt       <= '0;
      blink      <= 1'b0;
      blink_tick <= 1'b0;
    end else begin
      blink_tick <= b_wrap;
      if (b_wrap) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // LEDs without a button never advance.
  for (genvar i = 0; i < N_LED; i++) begin : g_map
    if (i < N_BTN) begin : g_btn
      assign adv[i] = press_nxt[i];
      assign clr[i] = long_nxt[i];
    end else begin : g_nobtn
      assign adv[i] = 1'b0;
      assign clr[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LED; i++)
        mode[i] <= M_OFF;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        if (clr[i])
          mode[i] <= M_OFF;
        else if (adv[i])
          mode[i] <= mode_t'(mode[i] + 2'd1);
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < N_LED; i++) begin
      unique case (mode[i])
        M_ON:    lit[i] = 1'b1;
        M_BLINK: lit[i] = sw_q[i] | blink;
        M_INV:   lit[i] = sw_q[i] | ~blink;
        default: lit[i] = sw_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      led <= LED_ACTIVE_LOW ? '1 : '0;
    else
      led <= LED_ACTIVE_LOW ? ~lit : lit;
  end

endmodule
